bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits between the calculator result (8-bit ALU/divider output) and the four-digit seven-segment driver. It replaces the pair of cascaded dividers (÷100, ÷10) with one iterative unit that uses a start/ready handshake. It also produces a leading-zero mask so the display can blank unused high digits.

Parameters:
BITS, 8, width of binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BITS-1; elaboration stops with an error otherwise.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request conversion; sampled only in IDLE or DONE.
bin  in  BITS  binary value; captured on the accepting edge.
busy  out  1  high while in SHIFT.
ready  out  1  one-cycle pulse, high in DONE; bcd/lead_zero valid from this cycle on.
bcd  out  4*DIGITS  packed result; digit k in [4k+3:4k], k=0 is units; held until next DONE.
lead_zero  out  DIGITS  bit k=1 when digit k and all higher digits are 0; bit 0 always 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, ready=0, bcd=0, lead_zero=0.
  - Internal shift and scratch registers cleared.
  - Reset during SHIFT aborts the conversion; no ready pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Load bin into shift register; clear BCD scratch; count=BITS; go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (4-bit, no carry between digits).
  - Then {scratch, shift} shifts left by 1; count decrements.
  - On the edge where count goes 1->0: go to DONE; register the final scratch into bcd and compute lead_zero.
- DONE (exactly one cycle):
  - ready=1, busy=0.
  - Next edge with start=1: capture bin and go straight to SHIFT (back-to-back).
  - Next edge with start=0: go to IDLE.
- Timing:
  - Latency: ready is high in the cycle after edge E_BITS (8 clocks after E0 for BITS=8).
  - Throughput with start held high: one result every BITS+1 cycles (9).
- start and bin changes during SHIFT are ignored; no queueing.
- bcd and lead_zero change only on entry to DONE or on reset. They are stable at all other times, so the display can read them continuously.
- Width rules:
  - Scratch is 4*DIGITS bits; shift register is BITS bits.
  - Counter is $clog2(BITS+1) bits.
  - No overflow is possible given the parameter constraint.
- lead_zero, for k from DIGITS-1 down to 1: bit k = (digit k==0) AND (k==DIGITS-1 OR lead_zero[k+1]). Bit 0 = 0.
- busy and ready are never high together. ready never lasts more than one cycle.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - BCD_DIGIT_W=4.
  - ADD3_THRESHOLD=4'd5.
- One natural sub-module, bcd_add3: combinational 4-bit "if >=5 add 3" corrector, instantiated DIGITS times by generate.
- The FSM, counter and output registers stay in bin2bcd_seq.

Test Plan:
- Assert rst=0 mid-run, then release:
  - During reset: busy=0, ready=0, bcd=12'h000, lead_zero=3'b000.
  - First start after release converts normally.
- bin=8'd255, single start pulse -> 8 clocks later ready=1 for one cycle, bcd=12'h255, lead_zero=3'b000.
- bin=8'd0 -> bcd=12'h000, lead_zero=3'b110.
- bin=8'd9 -> bcd=12'h009, lead_zero=3'b110.
- bin=8'd100 -> bcd=12'h100, lead_zero=3'b000.
- bin=8'd42 -> bcd=12'h042, lead_zero=3'b100.
- start held high, bin stepping 0..255 -> ready pulses every 9 cycles; each bcd equals the bin captured 8 cycles before that ready pulse; busy is never high together with ready.
- Start pulse with bin=8'd37, then during SHIFT change bin to 8'd200 and pulse start again -> only one ready, bcd=12'h037.
- rst low for 1 cycle in the 4th SHIFT cycle of a bin=8'd199 conversion -> no ready pulse; bcd=12'h000; a following start with bin=8'd199 gives 12'h199.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, digit width and add-3 threshold,
// plus a constant helper used to validate the parameters at elaboration.
package bin2bcd_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam int         BCD_DIGIT_W    = 4;
   localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

   // 10^n as a 64-bit constant; used only in elaboration-time checks.
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Purpose: single BCD digit corrector, adds 3 when the digit is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] d_o
);

   // Pre-correct so that the following left shift carries into the next digit.
   always_comb begin
      d_o = d_i;
      if (d_i >= ADD3_THRESHOLD) begin
         d_o = d_i + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: iterative double-dabble binary-to-BCD converter with leading-zero mask.
// Latency: ready pulses BITS cycles after the accepting edge; back-to-back every BITS+1.
// Backpressure: start is only sampled in IDLE/DONE; requests during SHIFT are dropped.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int BITS   = 8,
   parameter int DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BITS-1:0]         bin,
   output logic                    busy,
   output logic                    ready,
   output logic [4*DIGITS-1:0]     bcd,
   output logic [DIGITS-1:0]       lead_zero
);

   localparam int SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BITS + 1);

   // The result must fit in DIGITS decimal digits, otherwise the top digit overflows.
   if (pow10(DIGITS) <= ((64'd1 << BITS) - 64'd1)) begin : g_param_chk
      $error("bin2bcd_seq: DIGITS=%0d too small for BITS=%0d", DIGITS, BITS);
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BITS-1:0]    shift_q;
   logic [BITS-1:0]    shift_d;
   logic [SCR_W-1:0]   scratch_q;
   logic [SCR_W-1:0]   scratch_d;
   logic [SCR_W-1:0]   corr;
   logic [SCR_W-1:0]   bcd_q;
   logic [DIGITS-1:0]  lz_q;
   logic [DIGITS-1:0]  lz_d;
   logic               busy_q;
   logic               ready_q;

   // One corrector per digit; digits never carry into each other before the shift.
   for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (scratch_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
         .d_o (corr[BCD_DIGIT_W*k +: BCD_DIGIT_W])
      );
   end

   // Corrected scratch and binary shift register move left together by one bit.
   assign {scratch_d, shift_d} = {corr, shift_q} << 1;

   // Leading-zero mask from the final scratch: a digit is blank only if every digit above it is.
   always_comb begin
      logic run;
      lz_d = '0;
      run  = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         run     = run & (scratch_d[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
         lz_d[k] = run;
      end
   end

   // Control FSM, iteration counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         lz_q      <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  shift_q   <= bin;
                  scratch_q <= '0;
                  cnt_q     <= CNT_W'(BITS);
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               scratch_q <= scratch_d;
               shift_q   <= shift_d;
               cnt_q     <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  bcd_q   <= scratch_d;
                  lz_q    <= lz_d;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign ready     = ready_q;
   assign bcd       = bcd_q;
   assign lead_zero = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboarded bench for bin2bcd_seq: stimulus pushes expected results,
// a monitor pops and compares on every ready pulse and watches the
// handshake invariants every cycle.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        ready;
   logic [11:0] bcd;
   logic [2:0]  lead_zero;

   typedef struct {
      logic [11:0] bcd;
      logic [2:0]  lz;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   cyc;

   bin2bcd_seq #(.BITS(8), .DIGITS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin       (bin),
      .busy      (busy),
      .ready     (ready),
      .bcd       (bcd),
      .lead_zero (lead_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits by plain division.
   function automatic exp_t model(input int v, input int acc);
      exp_t e;
      e.bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      e.lz    = {v < 100, v < 10, 1'b0};
      e.acc   = acc;
      return e;
   endfunction

   task automatic drive_slot();
      @(negedge clk);
      #1;
   endtask

   // Single start pulse with the DUT known to be idle; waits for completion.
   task automatic pulse(input int v);
      drive_slot();
      start = 1'b1;
      bin   = 8'(v);
      @(posedge clk);
      #1;
      exp_q.push_back(model(v, cyc));
      start = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   // Monitor: samples at the falling edge, stimulus drives 1 time unit later.
   initial begin
      logic [11:0] prev_bcd;
      logic [2:0]  prev_lz;
      logic        prev_rdy;
      exp_t        e;
      prev_bcd = '0;
      prev_lz  = '0;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (busy && ready) chk("busy_and_ready", 1, 0);
            if (ready && prev_rdy) chk("ready_width", 1, 0);
            if (!ready) begin
               if (bcd !== prev_bcd)      chk("bcd_stable", bcd, prev_bcd);
               if (lead_zero !== prev_lz) chk("lz_stable", lead_zero, prev_lz);
            end
            if (ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_ready", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("bcd", bcd, e.bcd);
                  chk("lead_zero", lead_zero, e.lz);
                  chk("latency", cyc - e.acc, 8);
                  chk("busy_in_done", busy, 0);
               end
            end
         end
         prev_bcd = bcd;
         prev_lz  = lead_zero;
         prev_rdy = ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b0;
      start  = 1'b0;
      bin    = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      chk("rst_bcd", bcd, 12'h000);
      chk("rst_lz", lead_zero, 3'b000);
      repeat (3) @(posedge clk);
      drive_slot();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Directed values from the corners of the range.
      pulse(255);
      pulse(0);
      pulse(9);
      pulse(100);
      pulse(42);
      pulse(99);
      pulse(10);

      // Request during SHIFT is ignored.
      drive_slot();
      start = 1'b1;
      bin   = 8'd37;
      @(posedge clk);
      #1;
      exp_q.push_back(model(37, cyc));
      start = 1'b0;
      repeat (2) @(posedge clk);
      drive_slot();
      start = 1'b1;
      bin   = 8'd200;
      drive_slot();
      start = 1'b0;
      repeat (12) @(posedge clk);

      // Reset in the 4th SHIFT cycle aborts the conversion.
      drive_slot();
      start = 1'b1;
      bin   = 8'd199;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      drive_slot();
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_ready", ready, 0);
      chk("abort_bcd", bcd, 12'h000);
      chk("abort_lz", lead_zero, 3'b000);
      drive_slot();
      rst = 1'b1;
      repeat (12) @(posedge clk);
      chk("abort_bcd_after", bcd, 12'h000);
      pulse(199);

      // Randomised single conversions with random idle gaps.
      for (int i = 0; i < 24; i++) begin
         pulse(int'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // start held high: back-to-back conversions of 0..255.
      for (int v = 0; v < 256; v++) begin
         drive_slot();
         start = 1'b1;
         bin   = 8'(v);
         @(posedge clk);
         #1;
         exp_q.push_back(model(v, cyc));
         repeat (8) @(posedge clk);
      end
      drive_slot();
      start = 1'b0;
      repeat (12) @(posedge clk);

      chk("pending_results", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
